// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline control slice: controller states and counter limits.
// Used by pipeline_ctrl and hazard_detect.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IWAIT = 2'd1,
    DWAIT = 2'd2,
    HALT  = 2'd3
  } pipe_state_t;

  localparam int          REG_W     = 5;
  localparam int          CNT_W     = 32;
  localparam logic [31:0] STALL_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: flags a load in ID/EX whose destination feeds the
// instruction in IF/ID. Register 0 is hardwired, so it never creates a dependency.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  output logic             luse
);

  assign luse = idex_memread && (idex_rt != '0) &&
                ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller with a sticky halt state.
// Define PIPE_STALLCNT_EN to add the saturating stall_count output.
module pipeline_ctrl
  import cpu_types_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic [1:0]       mem_pcselect,
  input  logic             wb_halt,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halt
`ifdef PIPE_STALLCNT_EN
  ,output logic [CNT_W-1:0] stall_count
`endif
);

  pipe_state_t state, next_state;
  logic        luse;
  logic        data_wait;

  hazard_detect u_hazard (
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .luse         (luse)
  );

  assign data_wait = (mem_dREN || mem_dWEN) && !dhit;

  always_ff @(posedge CLK) begin
    if (RST) state <= RUN;
    else     state <= next_state;
  end

  // Priority chain: halt, data wait, redirect, load-use, fetch wait, normal.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    halt        = 1'b0;
    next_state  = state;

    if (RST) begin
      next_state = RUN;
    end else if (state == HALT || wb_halt) begin
      halt       = 1'b1;
      next_state = HALT;
    end else if (data_wait) begin
      next_state = DWAIT;
    end else begin
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
      next_state = RUN;
      if (mem_pcselect != 2'b00) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (luse) begin
        // Hold PC and IF/ID, inject a bubble into ID/EX.
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end else if (!ihit) begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
        next_state = IWAIT;
      end
    end
  end

`ifdef PIPE_STALLCNT_EN
  always_ff @(posedge CLK) begin
    if (RST)
      stall_count <= '0;
    else if (!pc_en && !halt && stall_count != STALL_MAX)
      stall_count <= stall_count + 32'd1;
  end
`endif

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: CLK in 1, rising-edge clock; RST in 1, synchronous active-high reset.
REQ-002 The block SHALL have these inputs:
- ihit in 1: instruction fetch complete this cycle.
- dhit in 1: data access complete this cycle.
- mem_dREN in 1 and mem_dWEN in 1: EX/MEM-stage load or store pending.
- mem_pcselect in 2: MEM-stage PC redirect, non-zero = taken branch or jump.
- wb_halt in 1: halt instruction in WB.
- idex_memread in 1: load in ID/EX.
- idex_rt in 5, ifid_rs in 5, ifid_rt in 5: register numbers.
REQ-003 The block SHALL have these outputs:
- pc_en out 1.
- ifid_en, idex_en, exmem_en, memwb_en out 1 each: latch write enables.
- ifid_flush, idex_flush, exmem_flush out 1 each: synchronous clear of the latch contents.
- halt out 1.
REQ-004 Under PIPE_STALLCNT_EN the block SHALL add stall_count out 32, the stall-cycle count.

Function
REQ-005 The block SHALL hold a registered FSM with states RUN, IWAIT, DWAIT, HALT; all outputs are combinational from the state and the current inputs, with zero-cycle latency.
REQ-006 Condition priority SHALL be, highest first: HALT state / wb_halt, data wait, redirect, load-use, instruction wait, normal.
REQ-007 HALT state or wb_halt=1: all enables SHALL be 0, all flushes 0 and halt=1; the next state SHALL be HALT, sticky until RST.
REQ-008 Data wait, meaning (mem_dREN|mem_dWEN)=1 and dhit=0: all enables and flushes SHALL be 0 and the next state SHALL be DWAIT.
REQ-009 In DWAIT with dhit=1: all enables SHALL be 1, and the remaining rules SHALL apply in the same cycle; the next state SHALL be RUN or IWAIT per those rules.
REQ-010 Redirect, meaning mem_pcselect!=0 and no data wait: pc_en and all enables SHALL be 1, and ifid_flush, idex_flush and exmem_flush SHALL be 1; the redirect SHALL override a simultaneous load-use and a simultaneous ihit=0.
REQ-011 Load-use, meaning idex_memread=1, idex_rt!=0 and idex_rt equals ifid_rs or ifid_rt: pc_en and ifid_en SHALL be 0, idex_en SHALL be 1 with idex_flush=1, and exmem_en and memwb_en SHALL be 1.
REQ-012 A load-use condition with idex_rt=0 SHALL NOT stall.
REQ-013 Instruction wait, meaning ihit=0 with no higher condition: pc_en SHALL be 0, ifid_en SHALL be 1 with ifid_flush=1, the downstream enables SHALL be 1, and the next state SHALL be IWAIT.
REQ-014 IWAIT with ihit=1 and no other condition SHALL return to RUN with normal outputs.
REQ-015 Normal operation: all enables SHALL be 1, all flushes 0 and halt=0.
REQ-016 A flush SHALL never be asserted while its own latch enable is 0.

Reset
REQ-017 While RST=1: state SHALL be RUN; all enables 0; all flushes 0; halt 0; stall_count 0 when present.
REQ-018 RST asserted in any state, including HALT or DWAIT, SHALL take effect at the next rising CLK edge; the cycle after RST deasserts SHALL behave as RUN.

Configuration
REQ-019 With PIPE_STALLCNT_EN defined: stall_count SHALL increment by 1 each cycle pc_en=0 outside HALT and reset, and SHALL saturate at 32'hFFFFFFFF with no wrap.
REQ-020 Without PIPE_STALLCNT_EN: the port and the counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-021 The state enum (RUN, IWAIT, DWAIT, HALT) SHALL be a typedef in cpu_types_pkg.
REQ-022 Load-use detection SHALL be a combinational sub-module, hazard_detect, outputting a single luse flag.
REQ-023 There SHALL be one FSM register and, when enabled, one counter register, with no other state.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset: RST=1 for 2 cycles, all inputs 0 → all enables 0; after RST deasserts with ihit=1 → all enables 1, state RUN.
- Load-use: idex_memread=1, idex_rt=5, ifid_rs=5, ihit=1 → pc_en=0, ifid_en=0, idex_flush=1 for exactly 1 cycle; repeat with idex_rt=0 → no stall.
- Data wait: mem_dREN=1, dhit=0 for 3 cycles then dhit=1 → enables 0 for 3 cycles (DWAIT), all 1 on the 4th; stall_count=3.
- Redirect with load-use: mem_pcselect=2'b01 together with the load-use condition → pc_en=1, ifid/idex/exmem flushes 1, no stall.
- Halt: wb_halt=1 for 1 cycle, then wb_halt=0 → halt=1 and enables 0 indefinitely; RST=1 → RUN.
- Counter saturation: counter preforced to 32'hFFFFFFFE, ihit=0 for 3 cycles → stall_count holds 32'hFFFFFFFF.
